// File: rtl/tone_pkg.sv
// Shared constants and types for the tone waveform PWM slice.
// Widths, the tone code type and the volume scaling helper.
package tone_pkg;

    localparam int PERIOD_W = 14;
    localparam int TONE_W   = 6;
    localparam int SAMPLE_W = 8;
    localparam int VOL_W    = 3;
    localparam int STEPS    = 64;
    localparam int STEP_W   = 6;
    localparam int PWM_W    = 8;

    typedef logic [TONE_W-1:0] tone_t;

    localparam tone_t TONE_REST = 6'd0;

    // (s * (v + 1)) >> VOL_W; max 255*8 >> 3 = 255, so no overflow
    function automatic logic [SAMPLE_W-1:0] scale_sample(
        input logic [SAMPLE_W-1:0] s,
        input logic [VOL_W-1:0]    v
    );
        logic [VOL_W:0]            gain;
        logic [SAMPLE_W+VOL_W:0]   prod;
        gain = (VOL_W+1)'(v) + (VOL_W+1)'(1);
        prod = (SAMPLE_W+VOL_W+1)'(s) * (SAMPLE_W+VOL_W+1)'(gain);
        return SAMPLE_W'(prod >> VOL_W);
    endfunction

endpackage

// File: rtl/tone_wave_pwm_if.sv
// Bundle between the tone look-up stage and the waveform/PWM stage.
// master drives enable/tone/period/volume; slave returns pwm_out/step_idx/sample/wave_wrap.
interface tone_wave_pwm_if import tone_pkg::*; ();

    logic                enable;
    tone_t               tone;
    logic [PERIOD_W-1:0] sixty_fourth_period;
    logic [VOL_W-1:0]    volume;

    logic                pwm_out;
    logic [STEP_W-1:0]   step_idx;
    logic [SAMPLE_W-1:0] sample;
    logic                wave_wrap;

    modport master (
        output enable, tone, sixty_fourth_period, volume,
        input  pwm_out, step_idx, sample, wave_wrap
    );

    modport slave (
        input  enable, tone, sixty_fourth_period, volume,
        output pwm_out, step_idx, sample, wave_wrap
    );

endinterface

// File: rtl/tone_wave_pwm_sine_lut64.sv
// Combinational 64-entry sine ROM, round_half_up(127.5 + 127.5*sin(2*pi*k/64)).
// Ports: idx (step 0..63) in, val (8-bit sample) out.
module sine_lut64 import tone_pkg::*; (
    input  logic [STEP_W-1:0]   idx,
    output logic [SAMPLE_W-1:0] val
);

    localparam logic [SAMPLE_W-1:0] ROM [STEPS] = '{
        8'd128, 8'd140, 8'd152, 8'd165, 8'd176, 8'd188, 8'd198, 8'd208,
        8'd218, 8'd226, 8'd234, 8'd240, 8'd245, 8'd250, 8'd253, 8'd254,
        8'd255, 8'd254, 8'd253, 8'd250, 8'd245, 8'd240, 8'd234, 8'd226,
        8'd218, 8'd208, 8'd198, 8'd188, 8'd176, 8'd165, 8'd152, 8'd140,
        8'd128, 8'd115, 8'd103, 8'd90,  8'd79,  8'd67,  8'd57,  8'd47,
        8'd37,  8'd29,  8'd21,  8'd15,  8'd10,  8'd5,   8'd2,   8'd1,
        8'd0,   8'd1,   8'd2,   8'd5,   8'd10,  8'd15,  8'd21,  8'd29,
        8'd37,  8'd47,  8'd57,  8'd67,  8'd79,  8'd90,  8'd103, 8'd115
    };

    assign val = ROM[idx];

endmodule

// File: rtl/tone_wave_pwm.sv
// Tone waveform stage: steps a sine table per 1/64 period, scales by volume, drives PWM.
// Ports: clk, rst_n (sync, active-low), bus (slave: enable/tone/period/volume in; pwm_out/step_idx/sample/wave_wrap out).
module tone_wave_pwm import tone_pkg::*; (
    input  logic            clk,
    input  logic            rst_n,
    tone_wave_pwm_if.slave  bus
);

    logic [PERIOD_W-1:0] active_period;
    logic [PERIOD_W-1:0] period_cnt;
    logic [STEP_W-1:0]   step_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic [SAMPLE_W-1:0] sine_val;
    logic [PWM_W-1:0]    pwm_cnt;
    logic                pwm_q;
    logic                wrap_q;

    logic running;
    logic boundary;
    logic mute;

    sine_lut64 u_lut (
        .idx (step_q),
        .val (sine_val)
    );

    // active_period==0 means no usable period yet: freeze and mute
    assign running  = active_period != '0;
    assign boundary = running
                    && (period_cnt == active_period - PERIOD_W'(1));
    assign mute     = !bus.enable
                    || (bus.tone == TONE_REST)
                    || !running;

    always_ff @(posedge clk) begin
        if (!rst_n || !bus.enable) begin
            active_period <= '0;
            period_cnt    <= '0;
            step_q        <= '0;
            sample_q      <= '0;
            pwm_cnt       <= '0;
            pwm_q         <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            pwm_cnt  <= pwm_cnt + PWM_W'(1);
            sample_q <= mute ? '0 : scale_sample(sine_val, bus.volume);
            pwm_q    <= !mute && (pwm_cnt < sample_q);
            wrap_q   <= boundary && (&step_q);

            // new period only takes effect on a step boundary
            if (!running || boundary)
                active_period <= bus.sixty_fourth_period;

            if (boundary) begin
                period_cnt <= '0;
                step_q     <= step_q + STEP_W'(1);
            end else if (running) begin
                period_cnt <= period_cnt + PERIOD_W'(1);
            end
        end
    end

    assign bus.pwm_out   = pwm_q;
    assign bus.step_idx  = step_q;
    assign bus.sample    = sample_q;
    assign bus.wave_wrap = wrap_q;

endmodule
